// File: rtl/inta_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : inta_sequencer                                                 |
// | Purpose : Interrupt-acknowledge sequencer that drives INT, places the    |
// |           vector byte on two INTA pulses and pulses ISR set/clear lines. |
// | Options : INTA_SYNC_EN adds a synchronizer flop ahead of INTA sampling.  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module inta_sequencer #(
    parameter int VECTOR_HI_W = 5,
    parameter int LEVEL_W     = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             INTA,
    input  logic                             intReq,
    input  logic [LEVEL_W-1:0]               irLevel,
    input  logic [VECTOR_HI_W-1:0]           TReg,
    input  logic                             AEOI,
    output logic                             INT,
    output logic [VECTOR_HI_W+LEVEL_W-1:0]   dataBus,
    output logic                             dataOE,
    output logic [(1<<LEVEL_W)-1:0]          setISR,
    output logic [(1<<LEVEL_W)-1:0]          clearISR,
    output logic                             freezeIRR,
    output logic                             spurious
);

    localparam int c_BUS_W   = VECTOR_HI_W + LEVEL_W;
    localparam int c_NUM_LVL = 1 << LEVEL_W;

    localparam logic [LEVEL_W-1:0]   c_SPUR_LEVEL = {LEVEL_W{1'b1}};
    localparam logic [c_NUM_LVL-1:0] c_ONE_HOT    = {{(c_NUM_LVL-1){1'b0}}, 1'b1};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_ACK1 = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_ACK2 = 3'd4;
    localparam logic [2:0] S_EOI  = 3'd5;

    logic [2:0]           state_q,     state_d;
    logic [LEVEL_W-1:0]   level_q,     level_d;
    logic                 spur_cyc_q,  spur_cyc_d;
    logic                 inta_smp_q,  inta_smp_d;
    logic                 inta_dly_q,  inta_dly_d;
    logic                 int_q,       int_d;
    logic [c_BUS_W-1:0]   data_bus_q,  data_bus_d;
    logic                 data_oe_q,   data_oe_d;
    logic [c_NUM_LVL-1:0] set_isr_q,   set_isr_d;
    logic [c_NUM_LVL-1:0] clear_isr_q, clear_isr_d;
    logic                 freeze_q,    freeze_d;
    logic                 spurious_q,  spurious_d;

    logic w_inta_in;
    logic w_fall;
    logic w_rise;

`ifdef INTA_SYNC_EN
    // Extra stage in front of the sampling register: one more cycle per edge.
    logic inta_meta_q, inta_meta_d;

    always_comb begin : p_sync_comb
        inta_meta_d = INTA;
        w_inta_in   = inta_meta_q;
    end

    always_ff @(posedge clk) begin : p_sync_reg
        if (!rst_n) begin
            inta_meta_q <= 1'b1;
        end else begin
            inta_meta_q <= inta_meta_d;
        end
    end
`else
    always_comb begin : p_sync_comb
        w_inta_in = INTA;
    end
`endif

    always_comb begin : p_edge_comb
        inta_smp_d = w_inta_in;
        inta_dly_d = inta_smp_q;
        w_fall     = inta_dly_q & ~inta_smp_q;
        w_rise     = ~inta_dly_q & inta_smp_q;
    end

    always_ff @(posedge clk) begin : p_state_reg
        if (!rst_n) begin
            state_q     <= S_IDLE;
            level_q     <= '0;
            spur_cyc_q  <= 1'b0;
            inta_smp_q  <= 1'b1;
            inta_dly_q  <= 1'b1;
            int_q       <= 1'b0;
            data_bus_q  <= '0;
            data_oe_q   <= 1'b0;
            set_isr_q   <= '0;
            clear_isr_q <= '0;
            freeze_q    <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            spur_cyc_q  <= spur_cyc_d;
            inta_smp_q  <= inta_smp_d;
            inta_dly_q  <= inta_dly_d;
            int_q       <= int_d;
            data_bus_q  <= data_bus_d;
            data_oe_q   <= data_oe_d;
            set_isr_q   <= set_isr_d;
            clear_isr_q <= clear_isr_d;
            freeze_q    <= freeze_d;
            spurious_q  <= spurious_d;
        end
    end

    always_comb begin : p_next_state
        state_d    = state_q;
        level_d    = level_q;
        spur_cyc_d = spur_cyc_q;
        case (state_q)
            S_IDLE: begin
                if (intReq) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // A request that vanished before the first acknowledge still
                // completes the bus cycle, but with the spurious level.
                if (w_fall) begin
                    state_d    = S_ACK1;
                    level_d    = intReq ? irLevel : c_SPUR_LEVEL;
                    spur_cyc_d = ~intReq;
                end
            end
            S_ACK1: begin
                if (w_rise) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (w_fall) begin
                    state_d = S_ACK2;
                end
            end
            S_ACK2: begin
                if (w_rise) begin
                    state_d = AEOI ? S_EOI : S_IDLE;
                end
            end
            S_EOI: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so every output is a flop
    // that changes on the same edge as the state register.
    always_comb begin : p_output_comb
        int_d       = (state_d == S_REQ);
        data_oe_d   = (state_d == S_ACK2);
        freeze_d    = (state_d == S_ACK1) || (state_d == S_GAP) ||
                      (state_d == S_ACK2) || (state_d == S_EOI);
        data_bus_d  = data_bus_q;
        set_isr_d   = '0;
        clear_isr_d = '0;
        spurious_d  = 1'b0;
        if (state_d == S_ACK2) begin
            data_bus_d = {TReg, level_d};
        end
        if ((state_q == S_REQ) && (state_d == S_ACK1)) begin
            if (intReq) begin
                set_isr_d = c_ONE_HOT << level_d;
            end else begin
                spurious_d = 1'b1;
            end
        end
        if ((state_d == S_EOI) && !spur_cyc_q) begin
            clear_isr_d = c_ONE_HOT << level_q;
        end
    end

    always_comb begin : p_output_drive
        INT       = int_q;
        dataBus   = data_bus_q;
        dataOE    = data_oe_q;
        setISR    = set_isr_q;
        clearISR  = clear_isr_q;
        freezeIRR = freeze_q;
        spurious  = spurious_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_inta_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_inta_sequencer                                              |
// | Purpose : Self-checking bench for inta_sequencer with randomized         |
// |           acknowledge cycles and transaction-level expectations.         |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_inta_sequencer;

`ifdef INTA_SYNC_EN
    localparam int c_EXP_LAT = 3;
`else
    localparam int c_EXP_LAT = 2;
`endif

    logic       clk;
    logic       rst_n;
    logic       INTA;
    logic       intReq;
    logic [2:0] irLevel;
    logic [4:0] TReg;
    logic       AEOI;
    logic       INT;
    logic [7:0] dataBus;
    logic       dataOE;
    logic [7:0] setISR;
    logic [7:0] clearISR;
    logic       freezeIRR;
    logic       spurious;

    int n_checks = 0;
    int n_errors = 0;

    // Observed-activity counters, owned solely by the monitor.
    int         n_set = 0, n_set_bad = 0, n_clr = 0, n_clr_bad = 0;
    int         n_spur = 0, n_oe = 0, n_int_bad = 0;
    logic [7:0] last_set = 8'h00, last_clr = 8'h00, last_bus = 8'h00;
    logic       prev_oe = 1'b0;

    inta_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .INTA      (INTA),
        .intReq    (intReq),
        .irLevel   (irLevel),
        .TReg      (TReg),
        .AEOI      (AEOI),
        .INT       (INT),
        .dataBus   (dataBus),
        .dataOE    (dataOE),
        .setISR    (setISR),
        .clearISR  (clearISR),
        .freezeIRR (freezeIRR),
        .spurious  (spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (setISR != 8'h00) begin
            n_set    <= n_set + 1;
            last_set <= setISR;
            if (INT || !freezeIRR || !$onehot(setISR)) n_set_bad <= n_set_bad + 1;
        end
        if (clearISR != 8'h00) begin
            n_clr    <= n_clr + 1;
            last_clr <= clearISR;
            if (!prev_oe || !$onehot(clearISR)) n_clr_bad <= n_clr_bad + 1;
        end
        if (spurious) n_spur <= n_spur + 1;
        if (dataOE) begin
            n_oe     <= n_oe + 1;
            last_bus <= dataBus;
        end
        // Leaving ACK2 must pass through IDLE, so INT cannot rise on that edge.
        if (prev_oe && !dataOE && INT) n_int_bad <= n_int_bad + 1;
        prev_oe <= dataOE;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full acknowledge transaction; expectations come from the vector and
    // pulse rules, not from the state sequence.
    task automatic run_ack(input logic [2:0] lvl, input logic [4:0] treg, input logic aeoi,
                           input logic spur, input logic keep,
                           input int low1, input int low2, input int hi);
        int b_set, b_sbad, b_clr, b_cbad, b_spur, b_oe, b_ibad;
        int lat;
        logic got_int;
        logic [2:0] exp_lvl;
        logic [7:0] exp_bus;
        logic [7:0] exp_onehot;
        exp_lvl    = spur ? 3'd7 : lvl;
        exp_bus    = {treg, exp_lvl};
        exp_onehot = 8'h01 << lvl;

        @(negedge clk);
        irLevel = lvl; TReg = treg; AEOI = aeoi; intReq = 1'b1;
        #1;
        b_set = n_set; b_sbad = n_set_bad; b_clr = n_clr; b_cbad = n_clr_bad;
        b_spur = n_spur; b_oe = n_oe; b_ibad = n_int_bad;

        got_int = 1'b0;
        for (int k = 0; k < 6 && !got_int; k++) begin
            @(negedge clk); #1;
            got_int = INT;
        end
        check("int_rise", 32'(got_int), 32'd1);
        if (spur) begin
            intReq = 1'b0;
            repeat (3) @(negedge clk);
            check("int_hold_after_drop", 32'(INT), 32'd1);
        end

        INTA = 1'b0;
        lat  = 0;
        for (int k = 1; k <= low1; k++) begin
            @(negedge clk);
            if (lat == 0 && (setISR != 8'h00 || spurious)) lat = k;
        end
        check("ack_latency", 32'(lat), 32'(c_EXP_LAT));
        intReq  = keep;
        irLevel = ~lvl;
        INTA    = 1'b1;
        repeat (hi) @(negedge clk);
        INTA = 1'b0;
        repeat (low2) @(negedge clk);
        INTA = 1'b1;
        repeat (hi + 4) @(negedge clk);
        #1;

        check("set_count", 32'(n_set - b_set), spur ? 32'd0 : 32'd1);
        if (!spur) check("set_value", 32'(last_set), 32'(exp_onehot));
        check("set_context", 32'(n_set_bad - b_sbad), 32'd0);
        check("spur_count", 32'(n_spur - b_spur), 32'(spur));
        check("oe_cycles", 32'(n_oe - b_oe), 32'(low2));
        check("bus_value", 32'(last_bus), 32'(exp_bus));
        check("bus_hold", 32'(dataBus), 32'(exp_bus));
        check("clr_count", 32'(n_clr - b_clr), 32'(aeoi && !spur));
        if (aeoi && !spur) check("clr_value", 32'(last_clr), 32'(exp_onehot));
        check("clr_timing", 32'(n_clr_bad - b_cbad), 32'd0);
        check("idle_gap", 32'(n_int_bad - b_ibad), 32'd0);
        check("freeze_end", 32'(freezeIRR), 32'd0);
        check("int_end", 32'(INT), 32'(keep));
    endtask

    initial begin
        int b_oe, b_set, b_clr, b_spur;
        rst_n = 1'b0; INTA = 1'b1; intReq = 1'b0; irLevel = 3'd0; TReg = 5'd0; AEOI = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_int", 32'(INT), 32'd0);
        check("rst_oe", 32'(dataOE), 32'd0);
        check("rst_freeze", 32'(freezeIRR), 32'd0);
        check("rst_spur", 32'(spurious), 32'd0);
        check("rst_bus", 32'(dataBus), 32'h00);
        check("rst_set", 32'(setISR), 32'h00);
        check("rst_clr", 32'(clearISR), 32'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases with fixed vectors.
        run_ack(3'd5, 5'b01110, 1'b0, 1'b0, 1'b0, 5, 5, 5);
        check("s1_bus", 32'(last_bus), 32'h75);
        check("s1_set", 32'(last_set), 32'h20);
        run_ack(3'd2, 5'b01110, 1'b1, 1'b0, 1'b0, 5, 5, 5);
        check("s2_bus", 32'(last_bus), 32'h72);
        check("s2_clr", 32'(last_clr), 32'h04);
        run_ack(3'd3, 5'b01110, 1'b0, 1'b1, 1'b0, 5, 5, 5);
        check("s3_bus", 32'(last_bus), 32'h77);

        // Reset while the vector is being driven.
        @(negedge clk);
        irLevel = 3'd6; TReg = 5'b10101; AEOI = 1'b1; intReq = 1'b1;
        repeat (3) @(negedge clk);
        INTA = 1'b0; repeat (5) @(negedge clk);
        intReq = 1'b0;
        INTA = 1'b1; repeat (5) @(negedge clk);
        INTA = 1'b0; repeat (c_EXP_LAT + 1) @(negedge clk);
        check("s4_in_ack2", 32'(dataOE), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("s4_oe", 32'(dataOE), 32'd0);
        check("s4_freeze", 32'(freezeIRR), 32'd0);
        check("s4_int", 32'(INT), 32'd0);
        #1;
        b_oe = n_oe; b_clr = n_clr; b_set = n_set; b_spur = n_spur;
        repeat (2) @(negedge clk);
        INTA = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("s4_no_clr", 32'(n_clr - b_clr), 32'd0);
        check("s4_no_oe", 32'(n_oe - b_oe), 32'd0);

        // INTA activity with no request pending.
        b_oe = n_oe; b_clr = n_clr; b_set = n_set; b_spur = n_spur;
        for (int p = 0; p < 3; p++) begin
            INTA = 1'b0; repeat (3) @(negedge clk);
            INTA = 1'b1; repeat (3) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        #1;
        check("s5_no_oe", 32'(n_oe - b_oe), 32'd0);
        check("s5_no_set", 32'(n_set - b_set), 32'd0);
        check("s5_no_clr", 32'(n_clr - b_clr), 32'd0);
        check("s5_no_spur", 32'(n_spur - b_spur), 32'd0);
        check("s5_int", 32'(INT), 32'd0);

        for (int it = 0; it < 14; it++) begin
            logic       r_spur;
            logic       r_keep;
            r_spur = ($urandom_range(3, 0) == 0);
            r_keep = r_spur ? 1'b0 : 1'($urandom_range(1, 0));
            run_ack(3'($urandom_range(7, 0)), 5'($urandom_range(31, 0)),
                    1'($urandom_range(1, 0)), r_spur, r_keep,
                    int'($urandom_range(7, 4)), int'($urandom_range(7, 1)),
                    int'($urandom_range(6, 3)));
        end

        intReq = 1'b0;
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL provide parameters (name, default, meaning), one per line:
- VECTOR_HI_W, 5, width of the TReg vector field.
- LEVEL_W, 3, width of the interrupt level field.
REQ-002 SHALL provide ports (name, direction, width, meaning), one per line:
- clk, input, 1, single clock; all state changes on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- INTA, input, 1, CPU interrupt acknowledge, active low, asynchronous to clk.
- intReq, input, 1, request from the interrupt priority logic.
- irLevel, input, 3, winning level from the priority logic.
- TReg, input, 5, upper vector bits from ICW2.
- AEOI, input, 1, automatic end-of-interrupt mode.
- INT, output, 1, interrupt line to the CPU.
- dataBus, output, 8, vector byte.
- dataOE, output, 1, dataBus drive enable.
- setISR, output, 8, one-hot one-cycle pulse that sets an ISR bit.
- clearISR, output, 8, one-hot one-cycle pulse that clears an ISR bit (AEOI only).
- freezeIRR, output, 1, holds IRR/priority stable during an acknowledge.
- spurious, output, 1, one-cycle pulse when a request vanished before the first acknowledge.
REQ-003 Reset SHALL be synchronous, active-low, on rst_n, with clk as the only clock.

Function
REQ-004 All outputs SHALL be registered.
REQ-005 The FSM states SHALL be IDLE, REQ, ACK1, GAP, ACK2 and EOI.
REQ-006 INTA SHALL pass through a sampling register, followed by a delay register for edge detection; fall = delayed & ~sampled, rise = ~delayed & sampled.
REQ-007 In IDLE with intReq=1, the FSM SHALL enter REQ on the next edge and INT SHALL be 1 while in REQ.
REQ-008 In REQ, a fall with intReq=1 SHALL latch irLevel and enter ACK1; a fall with intReq=0 SHALL latch level 7, pulse spurious, pulse no setISR bit, and enter ACK1.
REQ-009 On ACK1 entry, INT SHALL go to 0, setISR[latched level] SHALL pulse for one cycle (non-spurious only), and freezeIRR SHALL be 1 from ACK1 through the return to IDLE.
REQ-010 ACK1 SHALL move to GAP on rise; GAP SHALL move to ACK2 on the next fall.
REQ-011 In ACK2:
- dataBus SHALL be {TReg, latched level} and dataOE SHALL be 1.
- On rise, dataOE SHALL drop the same edge it leaves ACK2.
- The next state SHALL be EOI if AEOI=1 (sampled at ACK2 exit), otherwise IDLE.
REQ-012 EOI SHALL last exactly one cycle with clearISR[latched level] pulsed, then go to IDLE; a spurious cycle SHALL pulse no clearISR bit.
REQ-013 A fall while in IDLE SHALL be ignored: dataOE stays 0 and no pulses are produced.
REQ-014 In REQ, if intReq drops with no fall, the FSM SHALL stay in REQ with INT=1; only the first-acknowledge check of REQ-008 decides spurious.
REQ-015 Exiting ACK2 with intReq=1 SHALL pass through IDLE for at least one cycle before REQ.
REQ-016 With INTA_SYNC_EN off, the state change SHALL occur at edge E1, where E0 is the first edge sampling INTA=0.
REQ-017 dataBus SHALL hold its last value when dataOE=0.

Reset
REQ-018 While rst_n=0 at a clock edge:
- state SHALL be IDLE.
- INT, dataOE, freezeIRR and spurious SHALL be 0.
- dataBus, setISR and clearISR SHALL be 8'h00.
- the latched level SHALL be 0 and the sync/delay registers SHALL be 1.
REQ-019 Reset asserted mid-acknowledge (any state) SHALL abort the cycle with no further pulses; the cycle SHALL restart only from IDLE after rst_n=1.

Configuration
REQ-020 With macro INTA_SYNC_EN defined, a second synchronizer flop SHALL precede the sampling register, so the state change occurs at E2 (one extra cycle of latency on every edge).
REQ-021 Without INTA_SYNC_EN, INTA SHALL be sampled by a single register (REQ-016); all other behaviour is identical.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Scenario 1: intReq=1, irLevel=5, TReg=5'b01110, AEOI=0, two INTA low pulses (5 cycles low, 5 high each) -> INT rises, setISR=8'h20 for 1 cycle, dataBus=8'h75 with dataOE=1 during the 2nd pulse, no clearISR, back to IDLE.
- Scenario 2: same as scenario 1 with AEOI=1 and irLevel=2 -> setISR=8'h04, dataBus=8'h72, then clearISR=8'h04 for exactly 1 cycle after the 2nd INTA rises.
- Scenario 3: intReq pulses high and drops before the 1st INTA -> spurious=1 for one cycle, setISR stays 0, dataBus=8'h77.
- Scenario 4: rst_n=0 for one edge while in ACK2 -> dataOE=0, freezeIRR=0, INT=0 next cycle; no clearISR even with AEOI=1.
- Scenario 5: INTA toggled while idle with intReq=0 -> dataOE stays 0, all pulses 0. The bench SHALL also measure latency, INTA fall to setISR, in both builds: 2 cycles without INTA_SYNC_EN, 3 with it.
